qs_srt_range_sched: RTL

// - Quicksort range scheduler; sits directly upstream of the sort stack and drives its command port.
// - Holds pending {lo,hi} partition ranges on the stack and hands one range at a time to the partition engine.
// - Pushes the resulting sub-ranges back until the stack drains, then signals done.

---
 rtl/qs_srt_range_sched.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/qs_srt_range_sched.sv
// Quicksort range scheduler: seeds the sort stack with {0,n-1}, pops one range
//   at a time for the partition engine, pushes the surviving sub-ranges back
//   (larger first) and pulses done_r once the stack drains.
// Latency: done_r one cycle after start for n<2; otherwise each range costs
//   about 5 cycles of stack traffic plus engine time.
// Backpressure: rng_vld_r/rng_lo_r/rng_hi_r hold until rng_rdy; only one stack
//   command is ever in flight and each cmd_vld_r is a single-cycle pulse.
// Ports: clk, rst (sync, active-low); start/n command in; busy_r/done_r/err_r
//   status; rng_* range offer to the partition engine; part_done/part_pivot
//   engine result; cmd_* stack command out; head_r/head_vld_r/cmd_err_w/
//   empty_w/full_w stack response in.
// Optional build macro QS_SRT_RANGE_SCHED_STATS_EN adds stat_rng_r (ranges
//   issued, saturating) and stat_depth_r (peak stack occupancy).
module qs_srt_range_sched #(
  parameter  int N  = 16,
  parameter  int SN = 16,
  localparam int AW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW:0]     n,
  output logic            busy_r,
  output logic            done_r,
  output logic            err_r,
  output logic            rng_vld_r,
  input  logic            rng_rdy,
  output logic [AW-1:0]   rng_lo_r,
  output logic [AW-1:0]   rng_hi_r,
  input  logic            part_done,
  input  logic [AW-1:0]   part_pivot,
  output logic            cmd_vld_r,
  output logic            cmd_push_r,
  output logic [2*AW-1:0] cmd_push_dat_r,
  output logic            cmd_clr_r,
  input  logic [2*AW-1:0] head_r,
  input  logic            head_vld_r,
  input  logic            cmd_err_w,
  input  logic            empty_w,
  input  logic            full_w
`ifdef QS_SRT_RANGE_SCHED_STATS_EN
  ,
  output logic [15:0]     stat_rng_r,
  output logic [AW:0]     stat_depth_r
`endif
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEED,
    ST_CHK,
    ST_POP,
    ST_WAIT_HEAD,
    ST_OFFER,
    ST_WAIT_PART,
    ST_PUSH_A,
    ST_PUSH_B,
    ST_FIN
  } state_t;

  localparam logic [AW:0]   ONE_X = (AW+1)'(1);
  localparam logic [AW:0]   TWO_X = (AW+1)'(2);
  localparam logic [AW-1:0] ONE_A = AW'(1);

  state_t          state_r, state_d;
  logic            busy_d, done_d, err_d;
  logic            rng_vld_d;
  logic [AW-1:0]   rng_lo_d, rng_hi_d;
  logic            cmd_vld_d, cmd_push_d, cmd_clr_d;
  logic [2*AW-1:0] cmd_dat_d;
  logic [AW-1:0]   seed_hi_r, seed_hi_d;
  // Pending sub-ranges from the last partition, already in push order.
  logic            a_vld_r, a_vld_d, b_vld_r, b_vld_d;
  logic [2*AW-1:0] a_dat_r, a_dat_d, b_dat_r, b_dat_d;

  // Full stack status is not needed: overflow is reported through cmd_err_w.
  logic unused_ok;
  assign unused_ok = full_w & (SN > 0);

  // Sub-range split, evaluated one bit wider so p=0 or p=N-1 cannot wrap.
  logic [AW:0]     lo_x, hi_x, piv_x, len_l, len_r;
  logic            l_vld, r_vld, l_first;
  logic [2*AW-1:0] l_dat, r_dat;

  assign lo_x    = {1'b0, rng_lo_r};
  assign hi_x    = {1'b0, rng_hi_r};
  assign piv_x   = {1'b0, part_pivot};
  assign l_vld   = piv_x > (lo_x + ONE_X);
  assign r_vld   = hi_x > (piv_x + ONE_X);
  assign len_l   = piv_x - lo_x;
  assign len_r   = hi_x - piv_x;
  assign l_first = (len_l >= len_r);
  // Only meaningful when the matching *_vld is set, so the AW-bit +/-1 is safe.
  assign l_dat   = {rng_lo_r, part_pivot - ONE_A};
  assign r_dat   = {part_pivot + ONE_A, rng_hi_r};

  always_comb begin
    state_d    = state_r;
    busy_d     = busy_r;
    done_d     = 1'b0;
    err_d      = err_r;
    rng_vld_d  = 1'b0;
    rng_lo_d   = rng_lo_r;
    rng_hi_d   = rng_hi_r;
    cmd_vld_d  = 1'b0;
    cmd_push_d = cmd_push_r;
    cmd_dat_d  = cmd_push_dat_r;
    cmd_clr_d  = 1'b0;
    seed_hi_d  = seed_hi_r;
    a_vld_d    = a_vld_r;
    a_dat_d    = a_dat_r;
    b_vld_d    = b_vld_r;
    b_dat_d    = b_dat_r;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (n < TWO_X) begin
            done_d = 1'b1;
          end else begin
            busy_d    = 1'b1;
            cmd_clr_d = 1'b1;
            // n==N wraps to 0 in AW bits, so n-1 still lands on N-1.
            seed_hi_d = n[AW-1:0] - ONE_A;
            state_d   = ST_SEED;
          end
        end
      end
      ST_SEED: begin
        cmd_vld_d  = 1'b1;
        cmd_push_d = 1'b1;
        cmd_dat_d  = {{AW{1'b0}}, seed_hi_r};
        state_d    = ST_CHK;
      end
      ST_CHK: begin
        // While a command is still on the port, empty_w has not caught up yet.
        if (!cmd_vld_r) begin
          state_d = empty_w ? ST_FIN : ST_POP;
        end
      end
      ST_POP: begin
        cmd_vld_d  = 1'b1;
        cmd_push_d = 1'b0;
        state_d    = ST_WAIT_HEAD;
      end
      ST_WAIT_HEAD: begin
        if (head_vld_r) begin
          rng_lo_d  = head_r[2*AW-1:AW];
          rng_hi_d  = head_r[AW-1:0];
          rng_vld_d = 1'b1;
          state_d   = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (rng_rdy) begin
          state_d = ST_WAIT_PART;
        end else begin
          rng_vld_d = 1'b1;
        end
      end
      ST_WAIT_PART: begin
        if (part_done) begin
          if (l_vld && r_vld) begin
            a_vld_d = 1'b1;
            b_vld_d = 1'b1;
            a_dat_d = l_first ? l_dat : r_dat;
            b_dat_d = l_first ? r_dat : l_dat;
          end else begin
            a_vld_d = l_vld | r_vld;
            b_vld_d = 1'b0;
            a_dat_d = l_vld ? l_dat : r_dat;
          end
          state_d = ST_PUSH_A;
        end
      end
      ST_PUSH_A: begin
        if (a_vld_r) begin
          cmd_vld_d  = 1'b1;
          cmd_push_d = 1'b1;
          cmd_dat_d  = a_dat_r;
        end
        state_d = ST_PUSH_B;
      end
      ST_PUSH_B: begin
        // Leave a gap after the first push so commands never run back-to-back.
        if (!cmd_vld_r) begin
          if (b_vld_r) begin
            cmd_vld_d  = 1'b1;
            cmd_push_d = 1'b1;
            cmd_dat_d  = b_dat_r;
          end
          state_d = ST_CHK;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A stack fault ends the sort; done_r still pulses via FIN.
    if (cmd_err_w && (state_r != ST_IDLE) && (state_r != ST_FIN)) begin
      err_d     = 1'b1;
      state_d   = ST_FIN;
      cmd_vld_d = 1'b0;
      rng_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      err_r          <= 1'b0;
      rng_vld_r      <= 1'b0;
      rng_lo_r       <= '0;
      rng_hi_r       <= '0;
      cmd_vld_r      <= 1'b0;
      cmd_push_r     <= 1'b0;
      cmd_push_dat_r <= '0;
      cmd_clr_r      <= 1'b0;
      seed_hi_r      <= '0;
      a_vld_r        <= 1'b0;
      a_dat_r        <= '0;
      b_vld_r        <= 1'b0;
      b_dat_r        <= '0;
    end else begin
      state_r        <= state_d;
      busy_r         <= busy_d;
      done_r         <= done_d;
      err_r          <= err_d;
      rng_vld_r      <= rng_vld_d;
      rng_lo_r       <= rng_lo_d;
      rng_hi_r       <= rng_hi_d;
      cmd_vld_r      <= cmd_vld_d;
      cmd_push_r     <= cmd_push_d;
      cmd_push_dat_r <= cmd_dat_d;
      cmd_clr_r      <= cmd_clr_d;
      seed_hi_r      <= seed_hi_d;
      a_vld_r        <= a_vld_d;
      a_dat_r        <= a_dat_d;
      b_vld_r        <= b_vld_d;
      b_dat_r        <= b_dat_d;
    end
  end

`ifdef QS_SRT_RANGE_SCHED_STATS_EN
  logic        start_acc;
  logic [AW:0] occ_r;

  assign start_acc = (state_r == ST_IDLE) && start && (n >= TWO_X);

  // Shadow occupancy follows accepted commands only; faulted ones change nothing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_rng_r   <= '0;
      stat_depth_r <= '0;
      occ_r        <= '0;
    end else if (start_acc) begin
      stat_rng_r   <= '0;
      stat_depth_r <= '0;
      occ_r        <= '0;
    end else begin
      if (rng_vld_r && rng_rdy && (stat_rng_r != 16'hFFFF)) begin
        stat_rng_r <= stat_rng_r + 16'd1;
      end
      if (cmd_clr_r) begin
        occ_r <= '0;
      end else if (cmd_vld_r && !cmd_err_w) begin
        if (cmd_push_r) begin
          occ_r <= occ_r + ONE_X;
          if ((occ_r + ONE_X) > stat_depth_r) begin
            stat_depth_r <= occ_r + ONE_X;
          end
        end else begin
          occ_r <= occ_r - ONE_X;
        end
      end
    end
  end
`endif

endmodule
